// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner: per-key synchroniser, stability counter,
// press/release edge pulses and optional hold-to-repeat pulses.
module key_debounce_multi #(
    parameter int N_KEYS          = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_W           = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] keys_n,
    input  logic [N_KEYS-1:0] repeat_en,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] repeat_pulse
);

    localparam longint MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam longint MAX_CNT = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;

    generate
        if ((64'd1 << CNT_W) <= MAX_CNT) begin : g_bad_cnt_w
            $error("key_debounce_multi: CNT_W too small for the configured cycle counts");
        end
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
            $error("key_debounce_multi: DEBOUNCE_CYCLES must be at least 2");
        end
        if (N_KEYS < 1 || N_KEYS > 16) begin : g_bad_n_keys
            $error("key_debounce_multi: N_KEYS must be in 1..16");
        end
    endgenerate

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        logic [1:0]       sync;
        logic             s;
        logic             ks;
        logic [CNT_W-1:0] dcnt;
        logic [CNT_W-1:0] rcnt;
        logic             first;
        logic             accept;
        logic             rpt_hit;
        logic             press_q;
        logic             release_q;
        logic             repeat_q;

        assign s       = ~sync[1];
        assign accept  = (s != ks) && (dcnt == DB_LAST);
        assign rpt_hit = (rcnt == (first ? RD_LAST : RP_LAST));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync <= 2'b11;
            end else begin
                sync <= {sync[0], keys_n[i]};
            end
        end

        // Any cycle where the sampled level agrees with the accepted one restarts qualification.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ks        <= 1'b0;
                dcnt      <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= accept && s;
                release_q <= accept && !s;
                if (s == ks) begin
                    dcnt <= '0;
                end else if (dcnt == DB_LAST) begin
                    ks   <= s;
                    dcnt <= '0;
                end else begin
                    dcnt <= dcnt + CNT_W'(1);
                end
            end
        end

        // A release being accepted this cycle counts as "not held", so repeat never meets release.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rcnt     <= '0;
                first    <= 1'b1;
                repeat_q <= 1'b0;
            end else if (!ks || !repeat_en[i] || accept) begin
                rcnt     <= '0;
                first    <= 1'b1;
                repeat_q <= 1'b0;
            end else if (rpt_hit) begin
                rcnt     <= '0;
                first    <= 1'b0;
                repeat_q <= 1'b1;
            end else begin
                rcnt     <= rcnt + CNT_W'(1);
                repeat_q <= 1'b0;
            end
        end

        assign key_state[i]     = ks;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign repeat_pulse[i]  = repeat_q;
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed and randomized bench for key_debounce_multi against a window-based
// reference model of the debounce and repeat rules.
module tb_key_debounce_multi;

    localparam int N  = 3;
    localparam int D  = 8;
    localparam int RD = 20;
    localparam int RP = 5;
    localparam int W  = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] keys_n;
    logic [N-1:0] repeat_en;
    logic [N-1:0] key_state;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic [N-1:0] repeat_pulse;

    int checks   = 0;
    int failures = 0;

    key_debounce_multi #(
        .N_KEYS(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .keys_n(keys_n), .repeat_en(repeat_en),
        .key_state(key_state), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .repeat_pulse(repeat_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: raw pin history since reset, expected outputs, last repeat-restart edge.
    logic [N-1:0] raw_hist[$];
    int           t;
    logic [N-1:0] m_ks, m_press, m_rel, m_rpt;
    int           lc[N];

    task automatic chk_vec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit s_at(int ch, int tt);
        logic [N-1:0] v;
        if (tt < 2) return 1'b0;
        v = raw_hist[tt-2];
        return !v[ch];
    endfunction

    task automatic model_reset();
        raw_hist.delete();
        t       = 0;
        m_ks    = '0;
        m_press = '0;
        m_rel   = '0;
        m_rpt   = '0;
        for (int ch = 0; ch < N; ch++) lc[ch] = 0;
    endtask

    // One clock: predict from pre-edge inputs, clock, then compare #1 after the edge.
    task automatic tick();
        logic [N-1:0] nks, np, nr, nrp;
        bit flip, clr;
        raw_hist.push_back(keys_n);
        for (int ch = 0; ch < N; ch++) begin
            flip = (t >= D - 1);
            for (int j = 0; j < D; j++)
                if (s_at(ch, t - j) == m_ks[ch]) flip = 1'b0;
            clr     = !m_ks[ch] || !repeat_en[ch] || flip;
            nrp[ch] = !clr && (t - lc[ch] >= RD) && (((t - lc[ch] - RD) % RP) == 0);
            if (clr) lc[ch] = t;
            np[ch]  = flip && !m_ks[ch];
            nr[ch]  = flip && m_ks[ch];
            nks[ch] = m_ks[ch] ^ flip;
        end
        m_ks = nks; m_press = np; m_rel = nr; m_rpt = nrp;
        @(posedge clk);
        t++;
        #1;
        chk_vec("key_state", key_state, m_ks);
        chk_vec("press_pulse", press_pulse, m_press);
        chk_vec("release_pulse", release_pulse, m_rel);
        chk_vec("repeat_pulse", repeat_pulse, m_rpt);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk_vec("rst_key_state", key_state, '0);
        chk_vec("rst_press", press_pulse, '0);
        chk_vec("rst_release", release_pulse, '0);
        chk_vec("rst_repeat", repeat_pulse, '0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int p0, p2, cnt, first_rep, rel_at, rep_after, rep_cnt, rep0_after;
        rst_n     = 1'b1;
        keys_n    = '1;
        repeat_en = '0;
        #3;
        apply_reset();
        ticks(3);

        // Clean press on key 0, held 100 cycles
        keys_n[0] = 1'b0;
        p0 = -1; cnt = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (press_pulse[0]) begin cnt++; if (p0 < 0) p0 = k; end
        end
        chk_int("clean_press_latency", p0, 9);
        chk_int("clean_press_count", cnt, 1);
        keys_n[0] = 1'b1;
        ticks(15);

        // Bounce on key 1: toggles every 3 cycles, ends low
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            keys_n[1] = i[0];
            for (int k = 0; k < 3; k++) begin
                tick();
                if (press_pulse[1] || release_pulse[1]) cnt++;
            end
        end
        chk_int("bounce_no_pulse", cnt, 0);
        keys_n[1] = 1'b0;
        p0 = -1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (press_pulse[1] && p0 < 0) p0 = k;
        end
        chk_int("bounce_press_latency", p0, 9);
        keys_n[1] = 1'b1;
        ticks(15);

        // Glitch boundary on key 2
        keys_n[2] = 1'b0;
        cnt = 0;
        for (int k = 0; k < 7; k++) begin tick(); if (press_pulse[2]) cnt++; end
        keys_n[2] = 1'b1;
        for (int k = 0; k < 20; k++) begin tick(); if (press_pulse[2] || release_pulse[2]) cnt++; end
        chk_int("glitch7_no_pulse", cnt, 0);
        keys_n[2] = 1'b0;
        p0 = -1; rel_at = -1;
        for (int k = 0; k < 30; k++) begin
            if (k == 8) keys_n[2] = 1'b1;
            tick();
            if (press_pulse[2] && p0 < 0) p0 = k;
            if (release_pulse[2] && rel_at < 0) rel_at = k;
        end
        chk_int("glitch8_press", p0, 9);
        chk_int("glitch8_release", rel_at, 17);
        ticks(5);

        // Auto-repeat on key 0
        repeat_en = 3'b001;
        keys_n[0] = 1'b0;
        p0 = -1; first_rep = -1; rep_cnt = 0;
        for (int k = 0; k <= 69; k++) begin
            tick();
            if (press_pulse[0] && p0 < 0) p0 = k;
            if (repeat_pulse[0]) begin rep_cnt++; if (first_rep < 0) first_rep = k; end
        end
        chk_int("repeat_press", p0, 9);
        chk_int("repeat_first_offset", first_rep - p0, 20);
        chk_int("repeat_count_hold", rep_cnt, 9);
        keys_n[0] = 1'b1;
        rel_at = -1; rep_after = 0;
        for (int m = 0; m < 30; m++) begin
            tick();
            if (release_pulse[0] && rel_at < 0) rel_at = m;
            if (repeat_pulse[0] && rel_at >= 0) rep_after++;
        end
        chk_int("repeat_release_latency", rel_at, 9);
        chk_int("repeat_after_release", rep_after, 0);
        repeat_en = '0;

        // Simultaneous press on keys 0 and 2, one-cycle repeat_en[0] drop
        repeat_en = 3'b101;
        keys_n    = 3'b010;
        p0 = -1; p2 = -1; rep0_after = -1;
        for (int k = 0; k <= 80; k++) begin
            tick();
            if (press_pulse[0] && p0 < 0) p0 = k;
            if (press_pulse[2] && p2 < 0) p2 = k;
            if (repeat_pulse[0] && k > 32 && rep0_after < 0) rep0_after = k;
            if (k == 31) repeat_en[0] = 1'b0;
            if (k == 32) repeat_en[0] = 1'b1;
        end
        chk_int("simul_press0", p0, 9);
        chk_int("simul_press_equal", p2, p0);
        chk_int("simul_repeat_restart", rep0_after - p0, 43);
        keys_n    = '1;
        repeat_en = '0;
        ticks(15);

        // Reset while key 0 is accepted and key 1 is mid-count (dcnt=5)
        repeat_en = 3'b001;
        keys_n[0] = 1'b0;
        ticks(15);
        keys_n[1] = 1'b0;
        ticks(7);
        apply_reset();
        p0 = -1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (press_pulse[1] && p0 < 0) p0 = k;
        end
        chk_int("reset_repress_latency", p0, 9);
        keys_n    = '1;
        repeat_en = '0;
        ticks(15);

        // Randomized keys and repeat enables against the model
        for (int k = 0; k < 2000; k++) begin
            for (int ch = 0; ch < N; ch++) begin
                if ($urandom_range(5, 0) == 0) keys_n[ch] = ~keys_n[ch];
                if ($urandom_range(39, 0) == 0) repeat_en[ch] = ~repeat_en[ch];
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
